writeback_arbiter: RTL and testbench

- Sits directly upstream of the 32x32 register file and drives its single write port.
- Merges two result sources:
  - the in-order pipeline writeback, which has strict priority and no backpressure;
  - a long-latency unit (mul/div), which uses a valid/ready handshake.
- Long-latency results that lose arbitration are buffered in a small FIFO and drained when the write port is free.
- Exposes a pending-destination mask so the hazard unit can interlock on queued writes.

---
 rtl/writeback_arbiter.sv | 140 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | writeback_arbiter: register-file write-port arbiter, pipeline over mul/div |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module writeback_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iWbEn,
  input  logic [ADDRESS_WIDTH-1:0]      iWbAddress,
  input  logic [DATA_WIDTH-1:0]         iWbData,
  input  logic                          iLlValid,
  input  logic [ADDRESS_WIDTH-1:0]      iLlAddress,
  input  logic [DATA_WIDTH-1:0]         iLlData,
  output logic                          oLlReady,
  output logic                          oWriteEn,
  output logic [ADDRESS_WIDTH-1:0]      oWriteAddress,
  output logic [DATA_WIDTH-1:0]         oDataOut,
  output logic [(2**ADDRESS_WIDTH)-1:0] oPendingMask,
  output logic [CNT_WIDTH-1:0]          oConflictCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0]     FULL_OCC = OCC_W'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]         occ_q, occ_d;
  logic [CNT_WIDTH-1:0]     conflict_q, conflict_d;
  logic [ADDRESS_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_mem_d [DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem_d [DEPTH];

  logic pipe_wr;
  logic fifo_nonempty;
  logic ll_fire;
  logic bypass;
  logic push;
  logic pop;

  // Ready is a pure function of occupancy; reset forces it low immediately.
  assign oLlReady       = !iRst && (occ_q < FULL_OCC);
  assign oConflictCount = conflict_q;

  always_comb begin
    pipe_wr       = iWbEn && (iWbAddress != '0);
    fifo_nonempty = (occ_q != '0);
    ll_fire       = iLlValid && oLlReady;
    bypass        = !pipe_wr && !fifo_nonempty && ll_fire && (iLlAddress != '0);
    push          = ll_fire && (iLlAddress != '0) && !bypass;
    pop           = !pipe_wr && fifo_nonempty;
  end

  always_comb begin
    oWriteEn      = 1'b0;
    oWriteAddress = '0;
    oDataOut      = '0;
    if (!iRst) begin
      if (pipe_wr) begin
        oWriteEn      = 1'b1;
        oWriteAddress = iWbAddress;
        oDataOut      = iWbData;
      end else if (fifo_nonempty) begin
        oWriteEn      = 1'b1;
        oWriteAddress = addr_mem_q[rd_ptr_q];
        oDataOut      = data_mem_q[rd_ptr_q];
      end else if (bypass) begin
        oWriteEn      = 1'b1;
        oWriteAddress = iLlAddress;
        oDataOut      = iLlData;
      end
    end
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    conflict_d = conflict_q;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      addr_mem_d[wr_ptr_q] = iLlAddress;
      data_mem_d[wr_ptr_q] = iLlData;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    if (pipe_wr && fifo_nonempty && (conflict_q != CNT_MAX)) begin
      conflict_d = conflict_q + 1'b1;
    end
  end

  // Only entries within the occupied window, walking from the head, count.
  always_comb begin
    oPendingMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (OCC_W'(i) < occ_q) begin
        oPendingMask[addr_mem_q[rd_ptr_q + PTR_W'(i)]] = 1'b1;
      end
    end
    oPendingMask[0] = 1'b0;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      conflict_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      conflict_q <= conflict_d;
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// Directed-vector bench for writeback_arbiter: a cycle-by-cycle table plus a
// hand-written reset-while-buffered sequence.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ll_valid;
  logic [4:0]  ll_addr;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] mask;
  logic [15:0] conf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  writeback_arbiter dut (
    .iClk          (clk),
    .iRst          (rst),
    .iWbEn         (wb_en),
    .iWbAddress    (wb_addr),
    .iWbData       (wb_data),
    .iLlValid      (ll_valid),
    .iLlAddress    (ll_addr),
    .iLlData       (ll_data),
    .oLlReady      (ll_ready),
    .oWriteEn      (we),
    .oWriteAddress (waddr),
    .oDataOut      (wdata),
    .oPendingMask  (mask),
    .oConflictCount(conf)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic [31:0] e_mask;
    logic [15:0] e_conf;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [4:0] a, input logic [31:0] d,
                       input logic v, input logic [4:0] la, input logic [31:0] ld);
    wb_en = e; wb_addr = a; wb_data = d;
    ll_valid = v; ll_addr = la; ll_data = ld;
  endtask

  task automatic chk_all(input string tag, input logic e_we, input logic [4:0] e_wa,
                         input logic [31:0] e_wd, input logic e_rdy,
                         input logic [31:0] e_mask, input logic [15:0] e_conf);
    chk({tag, ".we"},   64'(we),       64'(e_we));
    chk({tag, ".wa"},   64'(waddr),    64'(e_wa));
    chk({tag, ".wd"},   64'(wdata),    64'(e_wd));
    chk({tag, ".rdy"},  64'(ll_ready), 64'(e_rdy));
    chk({tag, ".mask"}, 64'(mask),     64'(e_mask));
    chk({tag, ".conf"}, 64'(conf),     64'(e_conf));
  endtask

  initial begin
    //            we wa  wd            lv la  ld           | we wa  wd            rdy mask        conf
    vecs[0]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h0,        1, 32'h0,      16'd0};
    vecs[1]  = '{1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        1, 5,  32'hDEADBEEF, 1, 32'h0,      16'd0};
    vecs[2]  = '{1, 0,  32'h55,       0, 0,  32'h0,        0, 0,  32'h0,        1, 32'h0,      16'd0};
    vecs[3]  = '{0, 0,  32'h0,        1, 7,  32'h12,       1, 7,  32'h12,       1, 32'h0,      16'd0};
    vecs[4]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h0,        1, 32'h0,      16'd0};
    // pipeline x3 for four cycles, x8 / x9 arrive back-to-back
    vecs[5]  = '{1, 3,  32'hA0,       1, 8,  32'h88,       1, 3,  32'hA0,       1, 32'h0,      16'd0};
    vecs[6]  = '{1, 3,  32'hA1,       1, 9,  32'h99,       1, 3,  32'hA1,       1, 32'h100,    16'd0};
    vecs[7]  = '{1, 3,  32'hA2,       0, 0,  32'h0,        1, 3,  32'hA2,       0, 32'h300,    16'd1};
    vecs[8]  = '{1, 3,  32'hA3,       0, 0,  32'h0,        1, 3,  32'hA3,       0, 32'h300,    16'd2};
    vecs[9]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 8,  32'h88,       0, 32'h300,    16'd3};
    vecs[10] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 9,  32'h99,       1, 32'h200,    16'd3};
    vecs[11] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h0,        1, 32'h0,      16'd3};
    // rd=0 long-latency result while one entry is buffered
    vecs[12] = '{1, 4,  32'hB0,       1, 10, 32'hAA,       1, 4,  32'hB0,       1, 32'h0,      16'd3};
    vecs[13] = '{1, 4,  32'hB1,       1, 0,  32'hFF,       1, 4,  32'hB1,       1, 32'h400,    16'd3};
    vecs[14] = '{1, 4,  32'hB2,       0, 0,  32'h0,        1, 4,  32'hB2,       1, 32'h400,    16'd4};
    vecs[15] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 10, 32'hAA,       1, 32'h400,    16'd5};
    vecs[16] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h0,        1, 32'h0,      16'd5};
    // fill, then drain with iLlValid held: push/pop on same edge across wrap
    vecs[17] = '{1, 6,  32'hC0,       1, 11, 32'hB1,       1, 6,  32'hC0,       1, 32'h0,      16'd5};
    vecs[18] = '{1, 6,  32'hC1,       1, 12, 32'hB2,       1, 6,  32'hC1,       1, 32'h800,    16'd5};
    vecs[19] = '{0, 0,  32'h0,        1, 13, 32'hB3,       1, 11, 32'hB1,       0, 32'h1800,   16'd6};
    vecs[20] = '{0, 0,  32'h0,        1, 13, 32'hB3,       1, 12, 32'hB2,       1, 32'h1000,   16'd6};
    vecs[21] = '{0, 0,  32'h0,        1, 14, 32'hB4,       1, 13, 32'hB3,       1, 32'h2000,   16'd6};
    vecs[22] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 14, 32'hB4,       1, 32'h4000,   16'd6};
    vecs[23] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h0,        1, 32'h0,      16'd6};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 chk_all("reset", 0, 0, 0, 0, 32'h0, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].lv, vecs[i].la, vecs[i].ld);
      #1 chk_all($sformatf("v%0d", i), vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd,
                 vecs[i].e_rdy, vecs[i].e_mask, vecs[i].e_conf);
      @(negedge clk);
    end

    // Buffer x20 and x21 behind pipeline writes, then reset mid-cycle.
    drive(1, 3, 32'hD0, 1, 20, 32'h20);
    @(negedge clk);
    drive(1, 3, 32'hD1, 1, 21, 32'h21);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1 chk_all("pre_rst", 1, 20, 32'h20, 0, 32'h300000, 16'd7);
    #1 rst = 1'b1;
    #1 chk_all("mid_rst", 0, 0, 0, 0, 32'h0, 16'd0);
    drive(1, 5, 32'h77, 1, 9, 32'h9);
    #1 chk_all("rst_in", 0, 0, 0, 0, 32'h0, 16'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1 chk_all("post_rst0", 0, 0, 0, 1, 32'h0, 16'd0);
    @(negedge clk);
    #1 chk_all("post_rst1", 0, 0, 0, 1, 32'h0, 16'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
